// File: rtl/pwm_cap_pkg.sv
// Shared types and constants for the PWM capture path.
package pwm_cap_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_t;

  localparam int unsigned PCT_SCALE = 100;

  // One quotient bit per cycle, so latency equals the dividend width.
  function automatic int unsigned div_lat(input int unsigned cnt_w);
    return cnt_w + 7;
  endfunction

endpackage

// File: rtl/pwm_div.sv
// Sequential restoring divider: one quotient bit per cycle, done is a
// combinational pulse exactly N_W cycles after the start cycle.
module pwm_div #(
  parameter int unsigned N_W = 23,
  parameter int unsigned D_W = 16
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           start,
  input  logic           abort,
  input  logic [N_W-1:0] dividend,
  input  logic [D_W-1:0] divisor,
  output logic           busy,
  output logic           done,
  output logic [N_W-1:0] quotient
);

  localparam int unsigned C_W = $clog2(N_W + 1);

  logic           busy_q, busy_d;
  logic [C_W-1:0] cnt_q, cnt_d;
  logic [D_W-1:0] rem_q, rem_d;
  logic [D_W-1:0] dsr_q, dsr_d;
  logic [N_W-1:0] quo_q, quo_d;

  logic [D_W-1:0] rem_in;
  logic [D_W-1:0] dsr_in;
  logic [N_W-1:0] quo_in;
  logic [D_W:0]   trial;
  logic           fits;
  logic           stepping;

  assign stepping = busy_q && (cnt_q != '0);

  always_comb begin
    // The first step runs in the start cycle on the raw operands.
    rem_in = start ? '0 : rem_q;
    quo_in = start ? dividend : quo_q;
    dsr_in = start ? divisor : dsr_q;
    trial  = {rem_in, quo_in[N_W-1]};
    fits   = (trial >= {1'b0, dsr_in});

    busy_d = busy_q;
    cnt_d  = cnt_q;
    rem_d  = rem_q;
    quo_d  = quo_q;
    dsr_d  = dsr_q;

    if (start || stepping) begin
      rem_d = fits ? D_W'(trial - {1'b0, dsr_in}) : trial[D_W-1:0];
      quo_d = {quo_in[N_W-2:0], fits};
    end

    if (start) begin
      busy_d = 1'b1;
      cnt_d  = C_W'(N_W - 1);
      dsr_d  = divisor;
    end else if (stepping) begin
      cnt_d = cnt_q - 1'b1;
    end else if (busy_q) begin
      busy_d = 1'b0;
    end

    if (abort) busy_d = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      dsr_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dsr_q  <= dsr_d;
    end
  end

  assign busy     = busy_q;
  assign done     = busy_q && (cnt_q == '0);
  assign quotient = quo_q;

endmodule

// File: rtl/pwm_capture.sv
// Measures period/high time of an asynchronous PWM input, reports duty in
// percent and flags a stuck-high or stuck-low input after a timeout.
module pwm_capture
  import pwm_cap_pkg::*;
#(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned TIMEOUT_CYC = 50000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             enable,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] period_cnt,
  output logic [CNT_W-1:0] high_cnt,
  output logic [7:0]       duty_pct,
  output logic             valid,
  output logic             stuck_hi,
  output logic             stuck_lo,
  output logic             overrun,
  output state_t           dbg_state
);

  localparam int unsigned N_W = div_lat(CNT_W);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   s_dly_q, s_dly_d;
  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       per_run_q, per_run_d;
  logic [CNT_W-1:0]       hi_run_q, hi_run_d;
  logic [CNT_W-1:0]       to_cnt_q, to_cnt_d;
  logic [CNT_W-1:0]       period_q, period_d;
  logic [CNT_W-1:0]       high_q, high_d;
  logic [7:0]             duty_q, duty_d;
  logic                   valid_q, valid_d;
  logic                   stuck_hi_q, stuck_hi_d;
  logic                   stuck_lo_q, stuck_lo_d;
  logic                   overrun_q, overrun_d;

  logic           s, rise, timeout, div_free;
  logic           div_start, div_abort, div_busy, div_done;
  logic [N_W-1:0] quotient;

  assign s        = sync_q[SYNC_STAGES-1];
  assign rise     = s & ~s_dly_q;
  assign timeout  = enable && !rise && (to_cnt_q == CNT_W'(TIMEOUT_CYC));
  // A done cycle frees the divider, so a rise landing on it may start anew.
  assign div_free = !div_busy || div_done;

  always_comb begin
    sync_d     = (sync_q << 1) | SYNC_STAGES'(pwm_in);
    s_dly_d    = s;
    state_d    = state_q;
    per_run_d  = per_run_q;
    hi_run_d   = hi_run_q;
    to_cnt_d   = to_cnt_q;
    period_d   = period_q;
    high_d     = high_q;
    duty_d     = duty_q;
    valid_d    = 1'b0;
    stuck_hi_d = stuck_hi_q;
    stuck_lo_d = stuck_lo_q;
    overrun_d  = 1'b0;
    div_start  = 1'b0;
    div_abort  = 1'b0;

    if (!enable) begin
      state_d   = IDLE;
      per_run_d = '0;
      hi_run_d  = '0;
      to_cnt_d  = '0;
      div_abort = 1'b1;
    end else if (timeout) begin
      state_d   = IDLE;
      per_run_d = '0;
      hi_run_d  = '0;
      to_cnt_d  = '0;
      div_abort = 1'b1;
      valid_d   = 1'b1;
      period_d  = CNT_W'(TIMEOUT_CYC);
      if (s) begin
        stuck_hi_d = 1'b1;
        duty_d     = 8'(PCT_SCALE);
        high_d     = CNT_W'(TIMEOUT_CYC);
      end else begin
        stuck_lo_d = 1'b1;
        duty_d     = 8'd0;
        high_d     = '0;
      end
    end else begin
      if (div_done) begin
        duty_d  = (quotient > N_W'(PCT_SCALE)) ? 8'(PCT_SCALE) : quotient[7:0];
        valid_d = 1'b1;
      end
      if (rise) begin
        state_d    = MEASURE;
        per_run_d  = CNT_W'(1);
        hi_run_d   = CNT_W'(1);
        to_cnt_d   = CNT_W'(1);
        stuck_hi_d = 1'b0;
        stuck_lo_d = 1'b0;
        if (state_q == MEASURE) begin
          if (div_free) begin
            period_d  = per_run_q;
            high_d    = hi_run_q;
            div_start = 1'b1;
          end else begin
            overrun_d = 1'b1;
          end
        end
      end else begin
        // A latched stuck flag parks the timeout until the next edge.
        if (!stuck_hi_q && !stuck_lo_q) to_cnt_d = to_cnt_q + 1'b1;
        if (state_q == MEASURE) begin
          if (per_run_q != '1) per_run_d = per_run_q + 1'b1;
          if (s && (hi_run_q != '1)) hi_run_d = hi_run_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync_q     <= '0;
      s_dly_q    <= 1'b0;
      state_q    <= IDLE;
      per_run_q  <= '0;
      hi_run_q   <= '0;
      to_cnt_q   <= '0;
      period_q   <= '0;
      high_q     <= '0;
      duty_q     <= '0;
      valid_q    <= 1'b0;
      stuck_hi_q <= 1'b0;
      stuck_lo_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      s_dly_q    <= s_dly_d;
      state_q    <= state_d;
      per_run_q  <= per_run_d;
      hi_run_q   <= hi_run_d;
      to_cnt_q   <= to_cnt_d;
      period_q   <= period_d;
      high_q     <= high_d;
      duty_q     <= duty_d;
      valid_q    <= valid_d;
      stuck_hi_q <= stuck_hi_d;
      stuck_lo_q <= stuck_lo_d;
      overrun_q  <= overrun_d;
    end
  end

  pwm_div #(
    .N_W(N_W),
    .D_W(CNT_W)
  ) u_div (
    .CLK      (CLK),
    .RST      (RST),
    .start    (div_start),
    .abort    (div_abort),
    .dividend (N_W'(hi_run_q) * N_W'(PCT_SCALE)),
    .divisor  (per_run_q),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (quotient)
  );

  assign period_cnt = period_q;
  assign high_cnt   = high_q;
  assign duty_pct   = duty_q;
  assign valid      = valid_q;
  assign stuck_hi   = stuck_hi_q;
  assign stuck_lo   = stuck_lo_q;
  assign overrun    = overrun_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: steady duty, duty change, overrun,
// back-to-back boundary, stuck-high/low timeout and mid-divide reset.
module tb_pwm_capture;
  import pwm_cap_pkg::*;

  localparam int unsigned CNT_W       = 16;
  localparam int unsigned TIMEOUT_CYC = 3000;
  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned DIV_LAT     = CNT_W + 7;
  localparam int          CLK_NS      = 10;

  logic             clk = 1'b0;
  logic             rst;
  logic             enable;
  logic             pwm_in;
  logic [CNT_W-1:0] period_cnt;
  logic [CNT_W-1:0] high_cnt;
  logic [7:0]       duty_pct;
  logic             valid;
  logic             stuck_hi;
  logic             stuck_lo;
  logic             overrun;
  state_t           dbg_state;

  int   tests_run    = 0;
  int   tests_failed = 0;
  int   overrun_total = 0;
  time  valid_t_q[$];
  logic [7:0] duty_log[$];
  logic [7:0] exp_q[$];
  time  rise_t;
  int   base;
  int   ov0;

  // clock / reset block
  always #(CLK_NS/2) clk = ~clk;

  pwm_capture #(
    .CNT_W(CNT_W),
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .CLK        (clk),
    .RST        (rst),
    .enable     (enable),
    .pwm_in     (pwm_in),
    .period_cnt (period_cnt),
    .high_cnt   (high_cnt),
    .duty_pct   (duty_pct),
    .valid      (valid),
    .stuck_hi   (stuck_hi),
    .stuck_lo   (stuck_lo),
    .overrun    (overrun),
    .dbg_state  (dbg_state)
  );

  // Logs every valid cycle (time and duty) and counts overrun cycles.
  always @(negedge clk) begin
    if (valid === 1'b1) begin
      valid_t_q.push_back($time);
      duty_log.push_back(duty_pct);
    end
    if (overrun === 1'b1) overrun_total++;
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pwm_train(input int per, input int hi, input int n);
    for (int i = 0; i < n; i++) begin
      pwm_in = 1'b1;
      if (i == 1) rise_t = $time;
      tick(hi);
      pwm_in = 1'b0;
      tick(per - hi);
    end
  endtask

  task automatic gap();
    pwm_in = 1'b0;
    enable = 1'b0;
    tick(3);
    enable = 1'b1;
    tick(2);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] n_valid();
    return 32'(valid_t_q.size() - base);
  endfunction

  initial begin
    rst    = 1'b1;
    enable = 1'b0;
    pwm_in = 1'b0;
    rise_t = 0;
    tick(3);
    check("rst_period", 32'(period_cnt), 32'd0);
    check("rst_high", 32'(high_cnt), 32'd0);
    check("rst_duty", 32'(duty_pct), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_stuck_hi", 32'(stuck_hi), 32'd0);
    check("rst_stuck_lo", 32'(stuck_lo), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    rst    = 1'b0;
    enable = 1'b1;
    tick(2);

    // 100-cycle period, 40 high: 5 rises give 4 measurements.
    base = valid_t_q.size();
    ov0  = overrun_total;
    pwm_train(100, 40, 5);
    tick(40);
    check("t1_period", 32'(period_cnt), 32'd100);
    check("t1_high", 32'(high_cnt), 32'd40);
    check("t1_duty", 32'(duty_pct), 32'd40);
    check("t1_valid_cnt", n_valid(), 32'd4);
    check("t1_overrun", 32'(overrun_total - ov0), 32'd0);
    // pin edge -> sync -> start -> DIV_LAT -> registered valid
    check("t1_latency",
          (valid_t_q.size() > base) ? 32'((valid_t_q[base] - rise_t) / CLK_NS) : 32'd0,
          32'(SYNC_STAGES + DIV_LAT + 1));

    enable = 1'b0;
    tick(3);
    check("en_hold_period", 32'(period_cnt), 32'd100);
    check("en_hold_state", 32'(dbg_state), 32'(IDLE));
    enable = 1'b1;
    tick(2);

    // Period 1000: three at 800 high then three at 200 high.
    base = valid_t_q.size();
    ov0  = overrun_total;
    exp_q = '{8'd80, 8'd80, 8'd80, 8'd20, 8'd20};
    pwm_train(1000, 800, 3);
    pwm_train(1000, 200, 3);
    tick(40);
    check("t2_valid_cnt", n_valid(), 32'd5);
    for (int k = 0; k < 5; k++) begin
      check("t2_duty_seq",
            (duty_log.size() > base + k) ? 32'(duty_log[base + k]) : 32'hffff_ffff,
            32'(exp_q.pop_front()));
    end
    check("t2_period", 32'(period_cnt), 32'd1000);
    check("t2_high", 32'(high_cnt), 32'd200);
    check("t2_overrun", 32'(overrun_total - ov0), 32'd0);
    gap();

    // Period 3, high 1: an accepted rise every 24 cycles, the rest overrun.
    base = valid_t_q.size();
    ov0  = overrun_total;
    pwm_train(3, 1, 40);
    tick(40);
    check("t3_valid_cnt", n_valid(), 32'd5);
    check("t3_overrun_cnt", 32'(overrun_total - ov0), 32'd34);
    check("t3_period", 32'(period_cnt), 32'd3);
    check("t3_high", 32'(high_cnt), 32'd1);
    check("t3_duty", 32'(duty_pct), 32'd33);
    gap();

    // Period equal to DIV_LAT: rise coincides with done, no overrun.
    base = valid_t_q.size();
    ov0  = overrun_total;
    pwm_train(int'(DIV_LAT), 10, 6);
    tick(40);
    check("t4_valid_cnt", n_valid(), 32'd5);
    check("t4_overrun", 32'(overrun_total - ov0), 32'd0);
    check("t4_period", 32'(period_cnt), 32'(DIV_LAT));
    check("t4_duty", 32'(duty_pct), 32'd43);
    gap();

    // Stuck high.
    base = valid_t_q.size();
    pwm_train(100, 40, 2);
    pwm_in = 1'b1;
    tick(3500);
    check("t5_stuck_hi", 32'(stuck_hi), 32'd1);
    check("t5_stuck_lo", 32'(stuck_lo), 32'd0);
    check("t5_duty", 32'(duty_pct), 32'd100);
    check("t5_period", 32'(period_cnt), 32'(TIMEOUT_CYC));
    check("t5_high", 32'(high_cnt), 32'(TIMEOUT_CYC));
    check("t5_valid_cnt", n_valid(), 32'd3);
    check("t5_valid_duty",
          (duty_log.size() > 0) ? 32'(duty_log[duty_log.size() - 1]) : 32'd0, 32'd100);
    pwm_in = 1'b0;
    tick(20);
    pwm_in = 1'b1;
    tick(6);
    check("t5_clear", 32'(stuck_hi), 32'd0);

    // Stuck low, continuing from the clearing rise.
    base = valid_t_q.size();
    tick(10);
    pwm_in = 1'b0;
    tick(3500);
    check("t6_stuck_lo", 32'(stuck_lo), 32'd1);
    check("t6_stuck_hi", 32'(stuck_hi), 32'd0);
    check("t6_duty", 32'(duty_pct), 32'd0);
    check("t6_high", 32'(high_cnt), 32'd0);
    check("t6_period", 32'(period_cnt), 32'(TIMEOUT_CYC));
    check("t6_valid_cnt", n_valid(), 32'd1);
    pwm_in = 1'b1;
    tick(6);
    check("t6_clear", 32'(stuck_lo), 32'd0);
    gap();

    // Reset a few cycles after a divider start.
    pwm_train(100, 4, 1);
    pwm_in = 1'b1;
    tick(4);
    pwm_in = 1'b0;
    tick(4);
    rst = 1'b1;
    tick(1);
    check("t7_period", 32'(period_cnt), 32'd0);
    check("t7_high", 32'(high_cnt), 32'd0);
    check("t7_duty", 32'(duty_pct), 32'd0);
    check("t7_valid", 32'(valid), 32'd0);
    rst  = 1'b0;
    base = valid_t_q.size();
    tick(40);
    check("t7_no_valid", n_valid(), 32'd0);
    tick(60);
    pwm_train(100, 4, 3);
    tick(40);
    check("t7_resume_cnt", n_valid(), 32'd2);
    check("t7_resume_period", 32'(period_cnt), 32'd100);
    check("t7_resume_duty", 32'(duty_pct), 32'd4);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
